// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch PC generator: FSM state encoding and
// a power-of-two test used by elaboration-time parameter checks.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        RESET_S = 2'd0,
        RUN_S   = 2'd1,
        HALT_S  = 2'd2
    } pc_gen_state_e;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect arbiter: source 0 wins over all higher-numbered sources.
// redirect_pc is a flat vector with source 0 in the least significant PC_WIDTH bits.
module pc_redirect_arb #(
    parameter int PC_WIDTH     = 32,
    parameter int NUM_REDIRECT = 2
) (
    input  logic [NUM_REDIRECT-1:0]          redirect_valid,
    input  logic [NUM_REDIRECT*PC_WIDTH-1:0] redirect_pc,
    output logic                             any_valid,
    output logic [PC_WIDTH-1:0]              sel_pc
);

    logic [PC_WIDTH-1:0] src_pc [NUM_REDIRECT];

    for (genvar gi = 0; gi < NUM_REDIRECT; gi++) begin : g_unpack
        assign src_pc[gi] = redirect_pc[gi*PC_WIDTH +: PC_WIDTH];
    end

    // Scan from the lowest priority upward so the lowest valid index is the final winner.
    always_comb begin
        any_valid = 1'b0;
        sel_pc    = '0;
        for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
            if (redirect_valid[i]) begin
                any_valid = 1'b1;
                sel_pc    = src_pc[i];
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-group PC generator with prioritised redirects and epoch tagging.
// Optional feature macro QU_PC_GEN_MISALIGN_EN: aligns redirect targets and flags misaligned ones.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                    PC_WIDTH     = 32,
    parameter int                    PC_INC       = 4,
    parameter int                    FETCH_WIDTH  = 4,
    parameter int                    NUM_REDIRECT = 2,
    parameter int                    EPOCH_WIDTH  = 3,
    parameter logic [PC_WIDTH-1:0]   PC_RESET_VAL = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [NUM_REDIRECT-1:0]              redirect_valid,
    input  logic [NUM_REDIRECT*PC_WIDTH-1:0]     redirect_pc,
    input  logic                                 halt_req,
    input  logic                                 fetch_ready,
    output logic                                 fetch_valid,
    output logic [PC_WIDTH-1:0]                  fetch_pc,
    output logic [$clog2(FETCH_WIDTH):0]         fetch_count,
    output logic [EPOCH_WIDTH-1:0]               fetch_epoch,
`ifdef QU_PC_GEN_MISALIGN_EN
    output logic                                 redirect_misalign,
`endif
    output logic                                 halted
);

    localparam int                  LOG_INC     = $clog2(PC_INC);
    localparam int                  CNT_W       = $clog2(FETCH_WIDTH) + 1;
    localparam logic [PC_WIDTH-1:0] GROUP_BYTES = PC_WIDTH'(FETCH_WIDTH * PC_INC);
    localparam logic [PC_WIDTH-1:0] GROUP_MASK  = PC_WIDTH'(FETCH_WIDTH * PC_INC - 1);
    localparam logic [PC_WIDTH-1:0] SLOT_MASK   = PC_WIDTH'(FETCH_WIDTH - 1);

    if (!is_pow2(PC_INC)) begin : g_bad_pc_inc
        $error("pc_gen: PC_INC must be a power of 2");
    end
    if (!is_pow2(FETCH_WIDTH)) begin : g_bad_fetch_width
        $error("pc_gen: FETCH_WIDTH must be a power of 2");
    end
    if (NUM_REDIRECT < 1) begin : g_bad_num_redirect
        $error("pc_gen: NUM_REDIRECT must be at least 1");
    end

    pc_gen_state_e          state_reg;
    logic                   fetch_valid_reg;
    logic                   halted_reg;
    logic [PC_WIDTH-1:0]    fetch_pc_reg;
    logic [EPOCH_WIDTH-1:0] fetch_epoch_reg;

    logic                   redirect_any;
    logic [PC_WIDTH-1:0]    redirect_sel_pc;
    logic [PC_WIDTH-1:0]    redirect_load_pc;
    logic [PC_WIDTH-1:0]    seq_pc_next;
    logic [PC_WIDTH-1:0]    slot_idx;
    logic                   handshake;

    pc_redirect_arb #(
        .PC_WIDTH     (PC_WIDTH),
        .NUM_REDIRECT (NUM_REDIRECT)
    ) u_arb (
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .any_valid      (redirect_any),
        .sel_pc         (redirect_sel_pc)
    );

`ifdef QU_PC_GEN_MISALIGN_EN
    localparam logic [PC_WIDTH-1:0] INC_MASK = PC_WIDTH'(PC_INC - 1);
    logic redirect_misalign_reg;
    logic redirect_misalign_next;

    assign redirect_load_pc       = redirect_sel_pc & ~INC_MASK;
    assign redirect_misalign_next = redirect_any && ((redirect_sel_pc & INC_MASK) != '0);
    assign redirect_misalign      = redirect_misalign_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_misalign_reg <= 1'b0;
        end else begin
            redirect_misalign_reg <= redirect_misalign_next;
        end
    end
`else
    assign redirect_load_pc = redirect_sel_pc;
`endif

    assign handshake   = fetch_valid_reg & fetch_ready & en;
    assign seq_pc_next = (fetch_pc_reg & ~GROUP_MASK) + GROUP_BYTES;

    // Slot index of the start PC inside its aligned group; unaligned starts get fewer slots.
    assign slot_idx    = (fetch_pc_reg >> LOG_INC) & SLOT_MASK;
    assign fetch_count = CNT_W'(FETCH_WIDTH) - CNT_W'(slot_idx);

    assign fetch_valid = fetch_valid_reg;
    assign fetch_pc    = fetch_pc_reg;
    assign fetch_epoch = fetch_epoch_reg;
    assign halted      = halted_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RESET_S;
            fetch_valid_reg <= 1'b0;
            halted_reg      <= 1'b0;
            fetch_pc_reg    <= PC_RESET_VAL;
            fetch_epoch_reg <= '0;
        end else begin
            // A redirect overrides the sequential step but never touches the state.
            if (redirect_any) begin
                fetch_pc_reg    <= redirect_load_pc;
                fetch_epoch_reg <= fetch_epoch_reg + EPOCH_WIDTH'(1);
            end else if (handshake) begin
                fetch_pc_reg    <= seq_pc_next;
            end

            if (en) begin
                case (state_reg)
                    RESET_S: begin
                        state_reg       <= RUN_S;
                        fetch_valid_reg <= 1'b1;
                        halted_reg      <= 1'b0;
                    end
                    RUN_S: begin
                        if (halt_req && (!fetch_valid_reg || handshake)) begin
                            state_reg       <= HALT_S;
                            fetch_valid_reg <= 1'b0;
                            halted_reg      <= 1'b1;
                        end
                    end
                    HALT_S: begin
                        if (!halt_req) begin
                            state_reg       <= RUN_S;
                            fetch_valid_reg <= 1'b1;
                            halted_reg      <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg       <= RESET_S;
                        fetch_valid_reg <= 1'b0;
                        halted_reg      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen: default instance plus a high-reset-value instance for PC wrap.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt_req;
    logic        fetch_ready;

    logic        fetch_valid, fetch_valid_hi;
    logic [31:0] fetch_pc, fetch_pc_hi;
    logic [2:0]  fetch_count, fetch_count_hi;
    logic [2:0]  fetch_epoch, fetch_epoch_hi;
    logic        halted, halted_hi;
`ifdef QU_PC_GEN_MISALIGN_EN
    logic        misalign, misalign_hi;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .halt_req          (halt_req),
        .fetch_ready       (fetch_ready),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_count       (fetch_count),
        .fetch_epoch       (fetch_epoch),
`ifdef QU_PC_GEN_MISALIGN_EN
        .redirect_misalign (misalign),
`endif
        .halted            (halted)
    );

    pc_gen #(.PC_RESET_VAL(32'hFFFF_FFF0)) dut_hi (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .halt_req          (halt_req),
        .fetch_ready       (fetch_ready),
        .fetch_valid       (fetch_valid_hi),
        .fetch_pc          (fetch_pc_hi),
        .fetch_count       (fetch_count_hi),
        .fetch_epoch       (fetch_epoch_hi),
`ifdef QU_PC_GEN_MISALIGN_EN
        .redirect_misalign (misalign_hi),
`endif
        .halted            (halted_hi)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed view {valid, halted, pc, count, epoch} so one compare covers the whole group.
    function automatic logic [39:0] obs();
        return {fetch_valid, halted, fetch_pc, fetch_count, fetch_epoch};
    endfunction

    task automatic expect_grp(input string name, input logic v, input logic h,
                              input logic [31:0] pc, input logic [2:0] cnt, input logic [2:0] ep);
        logic [39:0] exp_v;
        exp_v = {v, h, pc, cnt, ep};
        tests++;
        if (obs() !== exp_v) begin
            fails++;
            $display("FAIL %s: got valid=%0b halted=%0b pc=%h count=%0d epoch=%0d, want valid=%0b halted=%0b pc=%h count=%0d epoch=%0d",
                     name, fetch_valid, halted, fetch_pc, fetch_count, fetch_epoch, v, h, pc, cnt, ep);
        end else begin
            $display("[TB] %s: pc=%h count=%0d epoch=%0d valid=%0b halted=%0b ok",
                     name, fetch_pc, fetch_count, fetch_epoch, fetch_valid, halted);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; fetch_ready = 1'b1; halt_req = 1'b0;
        redirect_valid = 2'b00; redirect_pc = '0;
        step();
        expect_grp("reset_state", 1'b0, 1'b0, 32'h0, 3'd4, 3'd0);
        rst = 1'b0;
        step();
        expect_grp("first_group", 1'b1, 1'b0, 32'h0, 3'd4, 3'd0);
        step();
        expect_grp("seq_0x10", 1'b1, 1'b0, 32'h10, 3'd4, 3'd0);
        step();
        expect_grp("seq_0x20", 1'b1, 1'b0, 32'h20, 3'd4, 3'd0);
    endtask

    task automatic test_redirect();
        redirect_valid = 2'b10;
        redirect_pc    = {32'h1008, 32'h0};
        step();
        expect_grp("redirect_src1", 1'b1, 1'b0, 32'h1008, 3'd2, 3'd1);
        redirect_valid = 2'b00;
        step();
        expect_grp("after_redirect", 1'b1, 1'b0, 32'h1010, 3'd4, 3'd1);
    endtask

    task automatic test_priority();
        redirect_valid = 2'b11;
        redirect_pc    = {32'h3000, 32'h2000};
        step();
        expect_grp("priority_src0", 1'b1, 1'b0, 32'h2000, 3'd4, 3'd2);
        redirect_valid = 2'b00;
        step();
        expect_grp("after_priority", 1'b1, 1'b0, 32'h2010, 3'd4, 3'd2);
    endtask

    task automatic test_stall();
        redirect_valid = 2'b01;
        redirect_pc    = {32'h0, 32'h20};
        step();
        expect_grp("redirect_0x20", 1'b1, 1'b0, 32'h20, 3'd4, 3'd3);
        redirect_valid = 2'b00;
        fetch_ready    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_grp("stall_hold", 1'b1, 1'b0, 32'h20, 3'd4, 3'd3);
        end
        fetch_ready = 1'b1;
        step();
        expect_grp("stall_release", 1'b1, 1'b0, 32'h30, 3'd4, 3'd3);
    endtask

    task automatic test_count_en();
        redirect_valid = 2'b01;
        redirect_pc    = {32'h0, 32'h100C};
        step();
        expect_grp("count_one", 1'b1, 1'b0, 32'h100C, 3'd1, 3'd4);
        redirect_valid = 2'b00;
        en = 1'b0;
        step();
        expect_grp("en_low_hold", 1'b1, 1'b0, 32'h100C, 3'd1, 3'd4);
        en = 1'b1;
        step();
        expect_grp("en_high_adv", 1'b1, 1'b0, 32'h1010, 3'd4, 3'd4);
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        step();
        expect_grp("halt_enter", 1'b0, 1'b1, 32'h1020, 3'd4, 3'd4);
        step();
        expect_grp("halt_stay", 1'b0, 1'b1, 32'h1020, 3'd4, 3'd4);
        redirect_valid = 2'b10;
        redirect_pc    = {32'h400, 32'h0};
        step();
        expect_grp("halt_redirect", 1'b0, 1'b1, 32'h400, 3'd4, 3'd5);
        redirect_valid = 2'b00;
        halt_req       = 1'b0;
        step();
        expect_grp("halt_exit", 1'b1, 1'b0, 32'h400, 3'd4, 3'd5);
        rst            = 1'b1;
        redirect_valid = 2'b11;
        redirect_pc    = {32'h800, 32'h900};
        step();
        expect_grp("rst_beats_redirect", 1'b0, 1'b0, 32'h0, 3'd4, 3'd0);
        rst            = 1'b0;
        redirect_valid = 2'b00;
    endtask

    task automatic test_wrap();
        rst = 1'b1; en = 1'b1; fetch_ready = 1'b1; halt_req = 1'b0; redirect_valid = 2'b00;
        step();
        rst = 1'b0;
        step();
        tests++;
        if ({fetch_valid_hi, fetch_pc_hi, fetch_count_hi} !== {1'b1, 32'hFFFF_FFF0, 3'd4}) begin
            fails++;
            $display("FAIL wrap_start: got valid=%0b pc=%h count=%0d, want valid=1 pc=fffffff0 count=4",
                     fetch_valid_hi, fetch_pc_hi, fetch_count_hi);
        end else begin
            $display("[TB] wrap_start: pc=%h ok", fetch_pc_hi);
        end
        step();
        tests++;
        if ({fetch_valid_hi, fetch_pc_hi, fetch_epoch_hi} !== {1'b1, 32'h0, 3'd0}) begin
            fails++;
            $display("FAIL wrap_zero: got valid=%0b pc=%h epoch=%0d, want valid=1 pc=00000000 epoch=0",
                     fetch_valid_hi, fetch_pc_hi, fetch_epoch_hi);
        end else begin
            $display("[TB] wrap_zero: pc=%h ok", fetch_pc_hi);
        end
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_priority();
        test_stall();
        test_count_en();
        test_halt();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
